hsv_pixel_rx: RTL
=================

Name: hsv_pixel_rx

Overview:
Front-end serial receiver between the Raspberry Pi GPIO link and the hand-mask/classifier path. It synchronises the Pi's bit clock and data line into the fpga_clk domain and detects Pi clock rising edges. It assembles 24-bit HSV words, LSB first, and emits one pixel per word with its row/column position. It also frames LENGTH×WIDTH pixels, signals frame completion, and aborts on link stall.

Parameters:
LENGTH, 32, image rows (from common package)
WIDTH, 32, image columns (from common package)
HSV_BITS, 24, bits per pixel word
SYNC_STAGES, 2, synchroniser depth (≥2)
TIMEOUT_CYCLES, 65536, fpga_clk cycles without a pi_clk edge mid-frame before abort

Ports:
fpga_clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
pi_clk  in  1  asynchronous Pi bit clock
data_in  in  1  asynchronous Pi data bit, valid at pi_clk rising edge
pix_valid  out  1  one-cycle pulse: pix_* fields valid
pix_hsv  out  HSV_BITS  assembled word: [7:0] hue, [15:8] sat, [23:16] value
pix_row  out  $clog2(LENGTH)  row of pixel
pix_col  out  $clog2(WIDTH)  column of pixel
frame_done  out  1  one-cycle pulse with final pixel of frame
frame_abort  out  1  one-cycle pulse on timeout abort
busy  out  1  high while in RECV

Behaviour:
- Reset (synchronous, rst wins over all events): state=IDLE. bit_cnt, row, col and timeout counter = 0. All outputs 0, including pix_hsv. Synchroniser and edge flops cleared to 0.
- pi_clk and data_in each pass through SYNC_STAGES flops. An extra flop on synced pi_clk feeds edge detection: edge = synced & ~prev. Data is taken from synced data_in in the edge cycle; both paths have identical depth.
- Latency: if edge N is the first fpga_clk edge to sample pi_clk high, the bit is captured at edge N+SYNC_STAGES. On the 24th bit, pix_valid is high in the cycle following that same edge.
- Input constraint: pi_clk high and low times ≥ SYNC_STAGES+1 fpga_clk cycles. Faster input is unsupported and unchecked.
- Bit k of a word goes to shift register bit k (LSB first). bit_cnt counts 0..HSV_BITS-1 and wraps to 0 after the last bit.
- pix_hsv, pix_row and pix_col are registered and hold their values until the next pix_valid. No backpressure: the consumer must accept every pulse.
- FSM:
  - IDLE: busy=0, no timeout. The first edge captures bit 0 and moves to RECV.
  - RECV: busy=1, captures bits. On each completed word, emits the pixel and advances col; at col=WIDTH-1, col←0 and row++.
  - Completing pixel (LENGTH-1, WIDTH-1) asserts frame_done in the same cycle as that pix_valid, clears row/col/bit_cnt and returns to IDLE.
  - Timeout in RECV: the counter clears on every edge and increments otherwise. When it reaches TIMEOUT_CYCLES-1 with no edge, frame_abort pulses, the partial word and position are discarded, and the FSM returns to IDLE. No pix_valid is issued for the partial word.
  - An edge in the same cycle the timeout would fire takes precedence; there is no abort.
- rst asserted mid-word or mid-frame discards everything; no frame_done or frame_abort is issued.
- Counter widths are exactly as ported. row never exceeds LENGTH-1 and col never exceeds WIDTH-1.

Decomposition:
- Package common: LENGTH, WIDTH, HSV_BITS.
- Package common: typedef hsv_t as a packed struct {value, saturation, hue} of 8 bits each, hue in the LSBs.
- Package common: rx_state_t enum {IDLE, RECV}.
- One sub-module, sync_edge_detect (params SYNC_STAGES): inputs async pi_clk/data_in; outputs synced data and a rise pulse.

Test Plan (LENGTH=WIDTH=4, SYNC_STAGES=2, TIMEOUT_CYCLES=64, pi_clk half-period 8 cycles):
- Send word 0x3C8014 LSB first → one pix_valid; pix_hsv=0x3C8014, row=0, col=0. pix_valid occurs 2 cycles after the 24th pi_clk rise is first sampled.
- Send 16 words, word i = i*0x010101 → 16 pix_valid pulses with row=i/4 and col=i%4. frame_done is asserted only with i=15; busy=0 afterwards.
- Send 10 bits, then hold pi_clk for 64 cycles → frame_abort pulses once with no pix_valid. A following full word appears at row=0, col=0 with the correct value.
- Complete 5 pixels, then assert rst for 1 cycle → all outputs 0, state IDLE. The next word is reported at (0,0) with no stale bits.
- Send two back-to-back frames with no gap → 32 pix_valid pulses and 2 frame_done pulses; the second frame restarts at (0,0).
- Timeout boundary: an edge arrives on exactly the cycle the counter reaches 63 → no abort and reception continues correctly.

Source files
------------

// File: rtl/hsv_pixel_rx_pkg.sv
// Shared image geometry, pixel word layout and receiver state encoding
// for the Pi-to-FPGA pixel link.
package hsv_pixel_rx_pkg;

    localparam int LENGTH   = 32;
    localparam int WIDTH    = 32;
    localparam int HSV_BITS = 24;

    // Hue sits in the LSBs, so it is the first byte shifted in from the Pi.
    typedef struct packed {
        logic [7:0] value;
        logic [7:0] saturation;
        logic [7:0] hue;
    } hsv_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RECV = ST_RECV
    } rx_state_t;

endpackage

// File: rtl/hsv_pixel_rx_sync.sv
// Brings the Pi bit clock and data line into the fpga_clk domain and
// flags each rising edge of the bit clock together with its data bit.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pi_clk,
    input  logic data_in,
    output logic data_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;

    // NOTE: non-blocking assignments make every stage take the previous stage's old value, which is what forms the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], pi_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_in};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    // Data and clock leave the chains at the same depth, so the bit lines up with its edge.
    assign data_sync = r_data_sync[SYNC_STAGES-1];
    assign rise      = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;

endmodule

// File: rtl/hsv_pixel_rx.sv
// Serial HSV pixel receiver: assembles 24-bit words LSB first, tags each
// with its row/column, frames LENGTH x WIDTH pixels and aborts on a stall.
module hsv_pixel_rx #(
    parameter int LENGTH         = hsv_pixel_rx_pkg::LENGTH,
    parameter int WIDTH          = hsv_pixel_rx_pkg::WIDTH,
    parameter int HSV_BITS       = hsv_pixel_rx_pkg::HSV_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                      fpga_clk,
    input  logic                      rst,
    input  logic                      pi_clk,
    input  logic                      data_in,
    output logic                      pix_valid,
    output logic [HSV_BITS-1:0]       pix_hsv,
    output logic [$clog2(LENGTH)-1:0] pix_row,
    output logic [$clog2(WIDTH)-1:0]  pix_col,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      busy
);
    import hsv_pixel_rx_pkg::*;

    localparam int ROW_W = $clog2(LENGTH);
    localparam int COL_W = $clog2(WIDTH);
    localparam int BIT_W = $clog2(HSV_BITS);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic w_rise;
    logic w_data;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (fpga_clk),
        .rst      (rst),
        .pi_clk   (pi_clk),
        .data_in  (data_in),
        .data_sync(w_data),
        .rise     (w_rise)
    );

    rx_state_t           r_state;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [HSV_BITS-1:0] r_shift;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [TMO_W-1:0]    r_tmo;

    logic                r_pix_valid;
    logic [HSV_BITS-1:0] r_pix_hsv;
    logic [ROW_W-1:0]    r_pix_row;
    logic [COL_W-1:0]    r_pix_col;
    logic                r_frame_done;
    logic                r_frame_abort;

    logic [HSV_BITS-1:0] w_word;
    logic                w_word_last;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_tmo_expired;

    // NOTE: w_word gets its full default before the single-bit override, so no latch is inferred.
    always_comb begin
        w_word            = r_shift;
        w_word[r_bit_cnt] = w_data;
    end

    assign w_word_last   = (r_bit_cnt == BIT_W'(HSV_BITS - 1));
    assign w_col_last    = (r_col == COL_W'(WIDTH - 1));
    assign w_row_last    = (r_row == ROW_W'(LENGTH - 1));
    assign w_tmo_expired = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_tmo         <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_hsv     <= '0;
            r_pix_row     <= '0;
            r_pix_col     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_pix_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;

            // An edge always wins over an expiring timeout.
            if (w_rise) begin
                r_tmo   <= '0;
                r_shift <= w_word;
                r_state <= RECV;
                if (w_word_last) begin
                    r_bit_cnt   <= '0;
                    r_pix_valid <= 1'b1;
                    r_pix_hsv   <= w_word;
                    r_pix_row   <= r_row;
                    r_pix_col   <= r_col;
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_row        <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (r_state == RECV) begin
                if (w_tmo_expired) begin
                    r_frame_abort <= 1'b1;
                    r_state       <= IDLE;
                    r_bit_cnt     <= '0;
                    r_shift       <= '0;
                    r_row         <= '0;
                    r_col         <= '0;
                    r_tmo         <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_hsv     = r_pix_hsv;
    assign pix_row     = r_pix_row;
    assign pix_col     = r_pix_col;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;
    assign busy        = (r_state == RECV);

endmodule
